// File: rtl/clock_set_ctrl_pkg.sv
// rtl/clock_set_ctrl_pkg.sv - shared encodings, field widths and wrap helpers for the time-set controller
package clock_set_ctrl_pkg;

  localparam int HOURS_W     = 5;
  localparam int MINUTES_W   = 6;
  localparam int SECONDS_W   = 6;
  localparam int HOURS_MAX   = 23;
  localparam int MINUTES_MAX = 59;

  localparam logic [1:0] ST_RUN         = 2'd0;
  localparam logic [1:0] ST_SET_HOURS   = 2'd1;
  localparam logic [1:0] ST_SET_MINUTES = 2'd2;
  localparam logic [1:0] ST_COMMIT      = 2'd3;

  typedef logic [HOURS_W-1:0]   hours_t;
  typedef logic [MINUTES_W-1:0] minutes_t;
  typedef logic [SECONDS_W-1:0] seconds_t;

  function automatic hours_t next_hours(input hours_t h);
    return (h == HOURS_W'(HOURS_MAX)) ? '0 : h + 1'b1;
  endfunction

  function automatic minutes_t next_minutes(input minutes_t m);
    return (m == MINUTES_W'(MINUTES_MAX)) ? '0 : m + 1'b1;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// rtl/clock_set_ctrl_if.sv - counter-chain and display link between time-set controller and datapath
interface clock_set_ctrl_if;
  import clock_set_ctrl_pkg::*;

  hours_t   q_hours;
  minutes_t q_minutes;
  logic     run_en;
  logic     load_strb;
  hours_t   ld_hours;
  minutes_t ld_minutes;
  seconds_t ld_seconds;
  logic     blink_hours;
  logic     blink_minutes;
  logic     edit_active;

  modport master (
    input  q_hours, q_minutes,
    output run_en, load_strb, ld_hours, ld_minutes, ld_seconds,
    output blink_hours, blink_minutes, edit_active
  );

  modport slave (
    output q_hours, q_minutes,
    input  run_en, load_strb, ld_hours, ld_minutes, ld_seconds,
    input  blink_hours, blink_minutes, edit_active
  );
endinterface

// File: rtl/clock_set_ctrl_btn_repeat.sv
// rtl/clock_set_ctrl_btn_repeat.sv - button rise detect with hold-then-auto-repeat event generation
module btn_repeat #(
  parameter int HOLD_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic evt
);
  localparam int CW = $clog2(HOLD_CYC + 1);
  localparam logic [CW-1:0] HOLD_LAST     = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REPEAT_RELOAD = CW'(HOLD_CYC - REPEAT_CYC);

  logic          btn_q;
  logic          rise;
  logic [CW-1:0] hold_cnt;

  assign rise = btn & ~btn_q;
  assign evt  = rise | (btn & btn_q & (hold_cnt == HOLD_LAST));

  // After the first repeat the counter restarts part-way so later repeats are REPEAT_CYC apart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q    <= 1'b0;
      hold_cnt <= '0;
    end else begin
      btn_q <= btn;
      if (!btn || rise)
        hold_cnt <= '0;
      else if (hold_cnt == HOLD_LAST)
        hold_cnt <= REPEAT_RELOAD;
      else
        hold_cnt <= hold_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - two-button time-set FSM: freeze, edit shadow hours/minutes, commit or time out
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int HOLD_CYC    = 25_000_000,
  parameter int REPEAT_CYC  = 5_000_000,
  parameter int TIMEOUT_SEC = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic tc_time_base,
  input  logic btn_mode,
  input  logic btn_inc,
  clock_set_ctrl_if.master cs
);
  localparam int TW = $clog2(TIMEOUT_SEC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_SEC - 1);

  logic [1:0]    state;
  hours_t        sh_hours;
  minutes_t      sh_minutes;
  logic [TW-1:0] to_cnt;
  logic          phase;
  logic          mode_q;
  logic          mode_rise;
  logic          inc_evt;

  assign mode_rise = btn_mode & ~mode_q;

  btn_repeat #(
    .HOLD_CYC  (HOLD_CYC),
    .REPEAT_CYC(REPEAT_CYC)
  ) u_inc (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_inc),
    .evt  (inc_evt)
  );

  // Priority inside edit states: mode edge, then increment, then timeout tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_RUN;
      sh_hours   <= '0;
      sh_minutes <= '0;
      to_cnt     <= '0;
      phase      <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      mode_q <= btn_mode;
      case (state)
        ST_RUN: begin
          if (mode_rise) begin
            state      <= ST_SET_HOURS;
            sh_hours   <= cs.q_hours;
            sh_minutes <= cs.q_minutes;
            to_cnt     <= '0;
            phase      <= 1'b0;
          end
        end
        ST_SET_HOURS, ST_SET_MINUTES: begin
          if (mode_rise) begin
            state  <= (state == ST_SET_HOURS) ? ST_SET_MINUTES : ST_COMMIT;
            to_cnt <= '0;
            phase  <= 1'b0;
          end else if (inc_evt) begin
            if (state == ST_SET_HOURS)
              sh_hours <= next_hours(sh_hours);
            else
              sh_minutes <= next_minutes(sh_minutes);
            to_cnt <= '0;
            phase  <= 1'b0;
          end else if (tc_time_base) begin
            if (to_cnt == TO_LAST) begin
              state  <= ST_RUN;
              to_cnt <= '0;
              phase  <= 1'b0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
              phase  <= ~phase;
            end
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign cs.run_en        = (state == ST_RUN);
  assign cs.load_strb     = (state == ST_COMMIT);
  assign cs.ld_hours      = sh_hours;
  assign cs.ld_minutes    = sh_minutes;
  assign cs.ld_seconds    = '0;
  assign cs.edit_active   = (state == ST_SET_HOURS) || (state == ST_SET_MINUTES);
  assign cs.blink_hours   = phase & (state == ST_SET_HOURS);
  assign cs.blink_minutes = phase & (state == ST_SET_MINUTES);
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - vector table, directed corner sequences and randomized run against a reference model
module tb_clock_set_ctrl;
  localparam int HOLD = 8;
  localparam int REP  = 4;
  localparam int TO   = 3;
  localparam int TICK = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tc_time_base = 1'b0;
  logic btn_mode = 1'b0;
  logic btn_inc = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   tick_cnt = 0;
  bit   chk_en = 1'b0;

  clock_set_ctrl_if cs_if();

  clock_set_ctrl #(
    .HOLD_CYC   (HOLD),
    .REPEAT_CYC (REP),
    .TIMEOUT_SEC(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tc_time_base(tc_time_base),
    .btn_mode    (btn_mode),
    .btn_inc     (btn_inc),
    .cs          (cs_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: state 0=run 1=hours 2=minutes 3=commit; blink phase is the parity of idle ticks.
  int m_state = 0, m_h = 0, m_m = 0, m_idle = 0, m_held = -1;
  bit m_mode_prev = 1'b0, m_inc_prev = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state <= 0; m_h <= 0; m_m <= 0; m_idle <= 0; m_held <= -1;
      m_mode_prev <= 1'b0; m_inc_prev <= 1'b0;
    end else begin : mstep
      int st, h, mn, idle, held;
      bit evt, mrise;
      st = m_state; h = m_h; mn = m_m; idle = m_idle; evt = 1'b0;
      mrise = btn_mode && !m_mode_prev;
      if (btn_inc && !m_inc_prev) begin
        held = 0; evt = 1'b1;
      end else if (btn_inc) begin
        held = m_held + 1;
        evt = (held >= HOLD) && ((held - HOLD) % REP == 0);
      end else begin
        held = -1;
      end
      if (st == 0) begin
        if (mrise) begin st = 1; h = cs_if.q_hours; mn = cs_if.q_minutes; idle = 0; end
      end else if (st == 3) begin
        st = 0;
      end else if (mrise) begin
        st = st + 1; idle = 0;
      end else if (evt) begin
        if (st == 1) h = (h + 1) % 24; else mn = (mn + 1) % 60;
        idle = 0;
      end else if (tc_time_base) begin
        idle = idle + 1;
        if (idle == TO) begin st = 0; idle = 0; end
      end
      m_state <= st; m_h <= h; m_m <= mn; m_idle <= idle; m_held <= held;
      m_mode_prev <= btn_mode; m_inc_prev <= btn_inc;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_run_en", cs_if.run_en, m_state == 0);
      check("m_load_strb", cs_if.load_strb, m_state == 3);
      check("m_edit_active", cs_if.edit_active, m_state == 1 || m_state == 2);
      check("m_ld_hours", cs_if.ld_hours, m_h);
      check("m_ld_minutes", cs_if.ld_minutes, m_m);
      check("m_ld_seconds", cs_if.ld_seconds, 0);
      check("m_blink_hours", cs_if.blink_hours, m_state == 1 && m_idle % 2 == 1);
      check("m_blink_minutes", cs_if.blink_minutes, m_state == 2 && m_idle % 2 == 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    tick_cnt = (tick_cnt + 1) % TICK;
    tc_time_base = (tick_cnt == 0);
  endtask

  task automatic pulse(input bit m, input bit i);
    btn_mode = m; btn_inc = i;
    step();
    btn_mode = 1'b0; btn_inc = 1'b0;
    step();
  endtask

  typedef struct {
    bit mode; bit inc;
    bit run_en; bit load; bit edit;
    int ldh; int ldm;
  } vec_t;
  vec_t tbl[12];

  initial begin
    bit seen_load;
    int mode_p, inc_p;

    tbl[0]  = '{1, 0, 0, 0, 1, 13, 45};
    tbl[1]  = '{0, 0, 0, 0, 1, 13, 45};
    tbl[2]  = '{0, 1, 0, 0, 1, 14, 45};
    tbl[3]  = '{0, 0, 0, 0, 1, 14, 45};
    tbl[4]  = '{0, 1, 0, 0, 1, 15, 45};
    tbl[5]  = '{0, 0, 0, 0, 1, 15, 45};
    tbl[6]  = '{1, 0, 0, 0, 1, 15, 45};
    tbl[7]  = '{0, 0, 0, 0, 1, 15, 45};
    tbl[8]  = '{0, 1, 0, 0, 1, 15, 46};
    tbl[9]  = '{0, 0, 0, 0, 1, 15, 46};
    tbl[10] = '{1, 0, 0, 1, 0, 15, 46};
    tbl[11] = '{0, 0, 1, 0, 0, 15, 46};

    cs_if.q_hours = 5'd13;
    cs_if.q_minutes = 6'd45;
    #1 reset = 1'b0;
    chk_en = 1'b1;
    repeat (3) step();
    check("rst_run_en", cs_if.run_en, 1);
    check("rst_load_strb", cs_if.load_strb, 0);
    check("rst_edit_active", cs_if.edit_active, 0);
    check("rst_ld_hours", cs_if.ld_hours, 0);
    check("rst_ld_minutes", cs_if.ld_minutes, 0);
    check("rst_blink", {cs_if.blink_hours, cs_if.blink_minutes}, 0);
    reset = 1'b1;
    step();

    // full set 13:45 -> 15:46
    for (int i = 0; i < 12; i++) begin
      btn_mode = tbl[i].mode; btn_inc = tbl[i].inc;
      step();
      check($sformatf("tbl%0d_run_en", i), cs_if.run_en, tbl[i].run_en);
      check($sformatf("tbl%0d_load", i), cs_if.load_strb, tbl[i].load);
      check($sformatf("tbl%0d_edit", i), cs_if.edit_active, tbl[i].edit);
      check($sformatf("tbl%0d_ld_hours", i), cs_if.ld_hours, tbl[i].ldh);
      check($sformatf("tbl%0d_ld_minutes", i), cs_if.ld_minutes, tbl[i].ldm);
    end
    btn_mode = 1'b0; btn_inc = 1'b0;
    step();

    // wrap both fields
    cs_if.q_hours = 5'd23; cs_if.q_minutes = 6'd59;
    pulse(1, 0);
    check("wrap_capture_h", cs_if.ld_hours, 23);
    pulse(0, 1);
    pulse(1, 0);
    pulse(0, 1);
    btn_mode = 1'b1;
    step();
    check("wrap_load", cs_if.load_strb, 1);
    check("wrap_ld_hours", cs_if.ld_hours, 0);
    check("wrap_ld_minutes", cs_if.ld_minutes, 0);
    btn_mode = 1'b0;
    step();
    check("wrap_back_run", cs_if.run_en, 1);
    check("wrap_load_done", cs_if.load_strb, 0);

    // auto-repeat: rise, +8, +12, +16, +20
    cs_if.q_hours = 5'd5; cs_if.q_minutes = 6'd10;
    pulse(1, 0);
    pulse(1, 0);
    btn_inc = 1'b1;
    repeat (21) step();
    btn_inc = 1'b0;
    step();
    check("repeat_ld_minutes", cs_if.ld_minutes, 15);
    check("repeat_still_edit", cs_if.edit_active, 1);
    pulse(1, 0);

    // timeout with no buttons
    pulse(1, 0);
    seen_load = 1'b0;
    for (int i = 0; i < 100 && cs_if.edit_active; i++) begin
      step();
      seen_load |= cs_if.load_strb;
    end
    check("timeout_exit", cs_if.edit_active, 0);
    check("timeout_no_load", seen_load, 0);
    check("timeout_run_en", cs_if.run_en, 1);

    // mode and inc rise together: mode wins
    cs_if.q_hours = 5'd7; cs_if.q_minutes = 6'd30;
    pulse(1, 0);
    pulse(1, 1);
    check("collide_ld_hours", cs_if.ld_hours, 7);
    pulse(0, 1);
    check("collide_in_minutes", cs_if.ld_minutes, 31);
    check("collide_hours_kept", cs_if.ld_hours, 7);

    // reset while in SET_MINUTES
    reset = 1'b0;
    #1;
    check("midrst_run_en", cs_if.run_en, 1);
    check("midrst_edit", cs_if.edit_active, 0);
    check("midrst_load", cs_if.load_strb, 0);
    check("midrst_ld_hours", cs_if.ld_hours, 0);
    check("midrst_ld_minutes", cs_if.ld_minutes, 0);
    check("midrst_blink", {cs_if.blink_hours, cs_if.blink_minutes}, 0);
    step();
    reset = 1'b1;
    seen_load = 1'b0;
    repeat (10) begin
      step();
      seen_load |= cs_if.load_strb;
    end
    check("midrst_no_load", seen_load, 0);

    // randomized run in varying button regimes
    for (int blk = 0; blk < 8; blk++) begin
      mode_p = ($urandom_range(1) == 0) ? 15 : 127;
      inc_p  = ($urandom_range(1) == 0) ? 5 : 40;
      repeat (400) begin
        if ($urandom_range(mode_p) == 0) btn_mode = ~btn_mode;
        if ($urandom_range(inc_p) == 0) btn_inc = ~btn_inc;
        if ($urandom_range(31) == 0) begin
          cs_if.q_hours = 5'($urandom_range(23));
          cs_if.q_minutes = 6'($urandom_range(59));
        end
        step();
      end
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
